// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants and FSM state type for the cache fill controller
package cache_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CHECK,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_FILL,
    ST_RESP
  } state_e;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// rtl/cache_fill_ctrl_if.sv - requester, cache and SDRAM port bundle of cache_fill_ctrl
interface cache_fill_ctrl_if
  import cache_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [NREQ-1:0]             i_req;
  logic [NREQ-1:0][ADDR_W-1:0] i_addr;
  logic [NREQ-1:0]             o_gnt;
  logic [NREQ-1:0]             o_rdvalid;
  logic [DATA_W-1:0]           o_rddata;

  logic                        o_c_en;
  logic                        o_c_wrt;
  logic [ADDR_W-1:0]           o_c_addr;
  logic [DATA_W-1:0]           o_c_data;
  logic [DATA_W-1:0]           i_c_data;
  logic                        i_c_success;

  logic                        o_mem_read;
  logic [ADDR_W-1:0]           o_mem_addr;
  logic                        i_mem_waitrequest;
  logic                        i_mem_readdatavalid;
  logic [DATA_W-1:0]           i_mem_readdata;

  modport master (
    input  i_req, i_addr, i_c_data, i_c_success,
           i_mem_waitrequest, i_mem_readdatavalid, i_mem_readdata,
    output o_gnt, o_rdvalid, o_rddata, o_c_en, o_c_wrt, o_c_addr, o_c_data,
           o_mem_read, o_mem_addr
  );

  modport slave (
    output i_req, i_addr, i_c_data, i_c_success,
           i_mem_waitrequest, i_mem_readdatavalid, i_mem_readdata,
    input  o_gnt, o_rdvalid, o_rddata, o_c_en, o_c_wrt, o_c_addr, o_c_data,
           o_mem_read, o_mem_addr
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting after the last accepted index
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NREQ-1:0]  req_i,
  input  logic             accept_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    if (found) gnt_o = NREQ'(1) << idx_o;
  end

  // Pointer resets to the last index so requester 0 has first priority.
  always_ff @(posedge i_clk) begin
    if (i_rst)         ptr_q <= IDX_W'(NREQ - 1);
    else if (accept_i) ptr_q <= idx_o;
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - arbitrated read path: cache lookup, SDRAM miss fetch, cache fill, response
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic               i_clk,
  input logic               i_rst,
  cache_fill_ctrl_if.master bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              c_en_q;
  logic              c_wrt_q;
  logic              mem_read_q;
  logic [NREQ-1:0]   rdvalid_q;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              accept;

  assign accept = (state_q == ST_IDLE) && (|bus.i_req);

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .req_i    (bus.i_req),
    .accept_i (accept),
    .gnt_o    (arb_gnt),
    .idx_o    (arb_idx)
  );

  // The grant is the only combinational output: it marks the IDLE cycle that accepts.
  assign bus.o_gnt      = accept ? arb_gnt : '0;
  assign bus.o_rdvalid  = rdvalid_q;
  assign bus.o_rddata   = data_q;
  assign bus.o_c_en     = c_en_q;
  assign bus.o_c_wrt    = c_wrt_q;
  assign bus.o_c_addr   = addr_q;
  assign bus.o_c_data   = data_q;
  assign bus.o_mem_read = mem_read_q;
  assign bus.o_mem_addr = addr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      c_en_q     <= 1'b0;
      c_wrt_q    <= 1'b0;
      mem_read_q <= 1'b0;
      rdvalid_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          idx_q   <= arb_idx;
          addr_q  <= bus.i_addr[arb_idx];
          c_en_q  <= 1'b1;
          c_wrt_q <= 1'b0;
          state_q <= ST_LOOKUP;
        end
        ST_LOOKUP: begin
          c_en_q  <= 1'b0;
          state_q <= ST_CHECK;
        end
        ST_CHECK: if (bus.i_c_success) begin
          data_q    <= bus.i_c_data;
          rdvalid_q <= NREQ'(1) << idx_q;
          state_q   <= ST_RESP;
        end else begin
          mem_read_q <= 1'b1;
          state_q    <= ST_MEM_REQ;
        end
        ST_MEM_REQ: if (!bus.i_mem_waitrequest) begin
          mem_read_q <= 1'b0;
          state_q    <= ST_MEM_WAIT;
        end
        // Read data arriving in any other state is dropped simply by not looking here.
        ST_MEM_WAIT: if (bus.i_mem_readdatavalid) begin
          data_q  <= bus.i_mem_readdata;
          c_en_q  <= 1'b1;
          c_wrt_q <= 1'b1;
          state_q <= ST_FILL;
        end
        ST_FILL: begin
          c_en_q    <= 1'b0;
          c_wrt_q   <= 1'b0;
          rdvalid_q <= NREQ'(1) << idx_q;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          rdvalid_q <= '0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - self-checking bench for cache_fill_ctrl with cache/SDRAM models
module tb_cache_fill_ctrl;

  localparam int NREQ = 4;
  localparam int AW   = 24;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  cache_fill_ctrl #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [NREQ-1:0] req_nx = '0;
  logic [AW-1:0]   addr_nx [NREQ];
  logic            rst_nx = 1'b1;
  bit              stray_nx = 1'b0;

  int              stall_left = 0;
  int              delay_cfg  = 1;
  int              dv_cnt     = 0;
  logic [AW-1:0]   dv_addr    = '0;

  logic [NREQ-1:0] s_gnt = '0, s_rdv = '0;
  logic [DW-1:0]   s_rddata = '0, s_c_data = '0;
  logic [AW-1:0]   s_c_addr = '0, s_mem_addr = '0, memrd_addr = '0;
  logic            s_c_en = 1'b0, s_c_wrt = 1'b0, s_mem_read = 1'b0, s_waitreq = 1'b0;
  logic            p_mem_read = 1'b0;
  logic [AW-1:0]   p_mem_addr = '0;

  int gnt_cyc[$], gnt_idx[$], rdv_cyc[$], rdv_idx[$];
  logic [DW-1:0] rdv_data[$], fill_data[$];
  logic [AW-1:0] fill_addr[$];
  int memrd_n = 0, onehot_bad = 0, memrd_unstable = 0;

  logic [DW-1:0] cmem        [logic [AW-1:0]];
  logic [DW-1:0] model_cache [logic [AW-1:0]];
  logic [DW-1:0] sdram       [logic [AW-1:0]];
  int model_last = NREQ - 1;

  typedef struct {
    logic [NREQ-1:0] mask;
    logic [AW-1:0]   addr;
    bit              pre;
    logic [DW-1:0]   pre_data;
    bit              sd;
    logic [DW-1:0]   sd_data;
    int              w;
    int              d;
    int              exp_g;
    int              exp_lat;
    logic [DW-1:0]   exp_data;
  } vec_t;
  vec_t vt [6];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  function automatic logic [DW-1:0] sd_val(input logic [AW-1:0] a);
    if (!sdram.exists(a)) sdram[a] = $urandom;
    return sdram[a];
  endfunction

  task automatic sample();
    s_gnt      = bus.o_gnt;
    s_rdv      = bus.o_rdvalid;
    s_rddata   = bus.o_rddata;
    s_c_en     = bus.o_c_en;
    s_c_wrt    = bus.o_c_wrt;
    s_c_addr   = bus.o_c_addr;
    s_c_data   = bus.o_c_data;
    s_mem_read = bus.o_mem_read;
    s_mem_addr = bus.o_mem_addr;
    s_waitreq  = bus.i_mem_waitrequest;
    if ($countones(s_gnt) > 1 || $countones(s_rdv) > 1) onehot_bad++;
    if (s_gnt != '0) begin gnt_cyc.push_back(cyc); gnt_idx.push_back(idx_of(s_gnt)); end
    if (s_rdv != '0) begin
      rdv_cyc.push_back(cyc); rdv_idx.push_back(idx_of(s_rdv)); rdv_data.push_back(s_rddata);
    end
    if (s_c_en && s_c_wrt) begin fill_addr.push_back(s_c_addr); fill_data.push_back(s_c_data); end
    if (s_mem_read) begin
      memrd_n++;
      memrd_addr = s_mem_addr;
      if (p_mem_read && s_mem_addr != p_mem_addr) memrd_unstable++;
    end
    p_mem_read = s_mem_read;
    p_mem_addr = s_mem_addr;
  endtask

  // One clock: drive inputs after the edge from the cache/SDRAM models, sample at the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_nx;
    bus.i_req = req_nx;
    for (int i = 0; i < NREQ; i++) bus.i_addr[i] = addr_nx[i];
    if (s_c_en && s_c_wrt) begin
      cmem[s_c_addr] = s_c_data;
      bus.i_c_success = 1'b1;
      bus.i_c_data = $urandom;
    end else if (s_c_en) begin
      bus.i_c_success = cmem.exists(s_c_addr);
      bus.i_c_data = cmem.exists(s_c_addr) ? cmem[s_c_addr] : $urandom;
    end else begin
      bus.i_c_success = 1'b0;
      bus.i_c_data = $urandom;
    end
    if (s_mem_read && !s_waitreq) begin dv_cnt = delay_cfg; dv_addr = s_mem_addr; end
    if (s_mem_read && s_waitreq && stall_left > 0) stall_left--;
    bus.i_mem_waitrequest   = (stall_left > 0);
    bus.i_mem_readdatavalid = 1'b0;
    bus.i_mem_readdata      = $urandom;
    if (dv_cnt > 0) begin
      dv_cnt--;
      if (dv_cnt == 0) begin bus.i_mem_readdatavalid = 1'b1; bus.i_mem_readdata = sd_val(dv_addr); end
    end
    if (stray_nx) begin bus.i_mem_readdatavalid = 1'b1; stray_nx = 1'b0; end
    @(negedge clk);
    sample();
  endtask

  task automatic run_txn(input string tag, input logic [NREQ-1:0] mask, input int w, input int d,
                         output int g, output int lat, output logic [DW-1:0] data);
    int n_g, n_r, k;
    n_g = gnt_cyc.size();
    n_r = rdv_cyc.size();
    stall_left = w;
    delay_cfg  = d;
    req_nx     = mask;
    g = -1; lat = -1; data = '0;
    k = 0;
    while (gnt_cyc.size() == n_g && k < 50) begin cycle(); k++; end
    req_nx = '0;
    if (gnt_cyc.size() == n_g) begin timeout({tag, " gnt"}); return; end
    g = gnt_idx[n_g];
    k = 0;
    while (rdv_cyc.size() == n_r && k < 100) begin cycle(); k++; end
    if (rdv_cyc.size() == n_r) begin timeout({tag, " rdvalid"}); return; end
    lat  = rdv_cyc[n_r] - gnt_cyc[n_g];
    data = rdv_data[n_r];
    chk({tag, " rdv_idx"}, rdv_idx[n_r], g);
  endtask

  task automatic check_side(input string tag, input bit miss, input logic [AW-1:0] a,
                            input logic [DW-1:0] d_exp, input int w, input int nf, input int nm);
    chk({tag, " fills"}, fill_addr.size() - nf, miss ? 1 : 0);
    if (miss && fill_addr.size() > nf) begin
      chk({tag, " fill_addr"}, fill_addr[nf], a);
      chk({tag, " fill_data"}, fill_data[nf], d_exp);
    end
    chk({tag, " mem_read_cycles"}, memrd_n - nm, miss ? 1 + w : 0);
    if (miss) chk({tag, " mem_addr"}, memrd_addr, a);
  endtask

  // Reference: winner is the first requester after the last one served; a miss costs 2 + stall + delay extra.
  task automatic model_txn(input string tag, input logic [NREQ-1:0] mask, input int w, input int d);
    int win, g, lat, nf, nm;
    logic [DW-1:0] data, exp_data;
    logic [AW-1:0] a;
    bit hit;
    win = -1;
    for (int k = 1; k <= NREQ; k++)
      if (win < 0 && mask[(model_last + k) % NREQ]) win = (model_last + k) % NREQ;
    a = addr_nx[win];
    hit = model_cache.exists(a);
    exp_data = hit ? model_cache[a] : sd_val(a);
    nf = fill_addr.size();
    nm = memrd_n;
    run_txn(tag, mask, w, d, g, lat, data);
    chk({tag, " gnt"}, g, win);
    chk({tag, " latency"}, lat, hit ? 3 : 5 + w + d);
    chk({tag, " data"}, data, exp_data);
    check_side(tag, !hit, a, exp_data, w, nf, nm);
    model_last = win;
    model_cache[a] = exp_data;
  endtask

  initial begin
    int g, lat, n_g, n_r, k;
    logic [DW-1:0] data;
    int exp_order [5];
    logic [NREQ-1:0] m;

    for (int i = 0; i < NREQ; i++) addr_nx[i] = '0;
    bus.i_req = '0; bus.i_addr = '0; bus.i_c_data = '0; bus.i_c_success = 1'b0;
    bus.i_mem_waitrequest = 1'b0; bus.i_mem_readdatavalid = 1'b0; bus.i_mem_readdata = '0;

    vt[0] = '{4'b0100, 24'h000010, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        0, 1, 2, 3,  32'hDEADBEEF};
    vt[1] = '{4'b0001, 24'h000123, 1'b0, 32'h0,        1'b1, 32'h12345678, 2, 4, 0, 11, 32'h12345678};
    vt[2] = '{4'b0001, 24'h000123, 1'b0, 32'h0,        1'b0, 32'h0,        0, 1, 0, 3,  32'h12345678};
    vt[3] = '{4'b1010, 24'h000200, 1'b0, 32'h0,        1'b1, 32'hCAFEF00D, 0, 1, 1, 6,  32'hCAFEF00D};
    vt[4] = '{4'b1010, 24'h000200, 1'b0, 32'h0,        1'b0, 32'h0,        0, 1, 3, 3,  32'hCAFEF00D};
    vt[5] = '{4'b1001, 24'h000300, 1'b0, 32'h0,        1'b1, 32'h0BADF00D, 1, 2, 0, 8,  32'h0BADF00D};

    // Reset state
    rst_nx = 1'b1;
    repeat (3) cycle();
    rst_nx = 1'b0;
    cycle();
    chk("reset o_gnt", s_gnt, 0);
    chk("reset o_rdvalid", s_rdv, 0);
    chk("reset o_rddata", s_rddata, 0);
    chk("reset o_c_en", s_c_en, 0);
    chk("reset o_c_wrt", s_c_wrt, 0);
    chk("reset o_c_addr", s_c_addr, 0);
    chk("reset o_c_data", s_c_data, 0);
    chk("reset o_mem_read", s_mem_read, 0);
    chk("reset o_mem_addr", s_mem_addr, 0);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      int nf, nm;
      string tag;
      tag = $sformatf("tbl%0d", i);
      for (int r = 0; r < NREQ; r++) addr_nx[r] = vt[i].addr;
      if (vt[i].pre) begin cmem[vt[i].addr] = vt[i].pre_data; model_cache[vt[i].addr] = vt[i].pre_data; end
      if (vt[i].sd) sdram[vt[i].addr] = vt[i].sd_data;
      nf = fill_addr.size();
      nm = memrd_n;
      run_txn(tag, vt[i].mask, vt[i].w, vt[i].d, g, lat, data);
      chk({tag, " gnt"}, g, vt[i].exp_g);
      chk({tag, " latency"}, lat, vt[i].exp_lat);
      chk({tag, " data"}, data, vt[i].exp_data);
      check_side(tag, vt[i].exp_lat != 3, vt[i].addr, vt[i].exp_data, vt[i].w, nf, nm);
      model_last = vt[i].exp_g;
      model_cache[vt[i].addr] = vt[i].exp_data;
    end

    // Stray read data in IDLE
    n_g = gnt_cyc.size(); n_r = rdv_cyc.size(); k = fill_addr.size(); g = memrd_n;
    stray_nx = 1'b1;
    repeat (5) cycle();
    chk("stray gnt", gnt_cyc.size() - n_g, 0);
    chk("stray rdvalid", rdv_cyc.size() - n_r, 0);
    chk("stray fills", fill_addr.size() - k, 0);
    chk("stray mem_read", memrd_n - g, 0);
    chk("stray c_en", s_c_en, 0);
    for (int r = 0; r < NREQ; r++) addr_nx[r] = 24'h000010;
    model_txn("after_stray", 4'b0100, 0, 1);

    // All requesters held high after reset
    rst_nx = 1'b1; cycle(); rst_nx = 1'b0;
    model_last = NREQ - 1;
    for (int r = 0; r < NREQ; r++) begin
      addr_nx[r] = 24'h000400 + AW'(r);
      cmem[addr_nx[r]] = 32'hA0000000 + DW'(r);
      model_cache[addr_nx[r]] = 32'hA0000000 + DW'(r);
    end
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    n_g = gnt_cyc.size(); n_r = rdv_cyc.size();
    req_nx = '1;
    k = 0;
    while (gnt_cyc.size() < n_g + 5 && k < 60) begin cycle(); k++; end
    req_nx = '0;
    k = 0;
    while (rdv_cyc.size() < n_r + 5 && k < 20) begin cycle(); k++; end
    if (gnt_cyc.size() < n_g + 5 || rdv_cyc.size() < n_r + 5) timeout("rr_all");
    else begin
      repeat (3) cycle();
      chk("rr_all gnt_count", gnt_cyc.size() - n_g, 5);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("rr_all order%0d", i), gnt_idx[n_g + i], exp_order[i]);
        chk($sformatf("rr_all rdv%0d", i), rdv_idx[n_r + i], exp_order[i]);
        chk($sformatf("rr_all data%0d", i), rdv_data[n_r + i], 32'hA0000000 + DW'(exp_order[i]));
        if (i > 0) chk($sformatf("rr_all spacing%0d", i), gnt_cyc[n_g + i] - gnt_cyc[n_g + i - 1], 4);
      end
    end
    model_last = 0;

    // Reset while waiting for SDRAM data; the data arrives after the reset
    for (int r = 0; r < NREQ; r++) addr_nx[r] = 24'h000500;
    n_g = gnt_cyc.size(); n_r = rdv_cyc.size(); k = fill_addr.size();
    stall_left = 0; delay_cfg = 6; req_nx = 4'b0010;
    g = 0;
    while (gnt_cyc.size() == n_g && g < 20) begin cycle(); g++; end
    req_nx = '0;
    if (gnt_cyc.size() == n_g) timeout("rst_mid gnt");
    else chk("rst_mid gnt", gnt_idx[n_g], 1);
    repeat (4) cycle();
    rst_nx = 1'b1; cycle(); rst_nx = 1'b0;
    repeat (12) cycle();
    chk("rst_mid fills", fill_addr.size() - k, 0);
    chk("rst_mid rdvalid", rdv_cyc.size() - n_r, 0);
    chk("rst_mid gnt_count", gnt_cyc.size() - n_g, 1);
    chk("rst_mid c_en", s_c_en, 0);
    chk("rst_mid mem_read", s_mem_read, 0);
    model_last = NREQ - 1;
    model_txn("rst_mid retry", 4'b1111, 0, 1);

    // Randomized transactions
    for (int it = 0; it < 40; it++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int r = 0; r < NREQ; r++) addr_nx[r] = 24'h000600 + AW'($urandom_range(0, 7));
      stray_nx = ($urandom_range(0, 3) == 0);
      model_txn($sformatf("rand%0d", it), m, $urandom_range(0, 3), $urandom_range(1, 4));
    end

    chk("onehot violations", onehot_bad, 0);
    chk("mem_addr unstable", memrd_unstable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
